gray_to_rgb: RTL and testbench

Pixel-stream back-end stage that converts an 8-bit grayscale (Sobel magnitude) sample into a 24-bit RGB triple for display/VGA output. It sits after the Sobel edge-magnitude stage and before the frame writer. Data moves through it with a fixed one-cycle registered latency, qualified by a `done` strobe. By default it replicates gray onto R, G and B. An optional build-time feature maps gray to a pseudocolor heat map.

---
 rtl/gray_to_rgb_pkg.sv | 20 ++
 rtl/gray_colormap.sv | 53 +++++
 rtl/gray_to_rgb.sv | 49 ++++
 tb/tb_gray_to_rgb.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/gray_to_rgb_pkg.sv
// Shared types and constants for the gray_to_rgb pixel stage.
// The heat-map option is selected with GRAY_TO_RGB_PSEUDOCOLOR_EN.
package gray_to_rgb_pkg;

  localparam int DATA_W = 8;

  typedef struct packed {
    logic [DATA_W-1:0] r;
    logic [DATA_W-1:0] g;
    logic [DATA_W-1:0] b;
  } rgb_t;

  localparam logic [1:0] SEG_BLUE_CYAN    = 2'd0;
  localparam logic [1:0] SEG_CYAN_GREEN   = 2'd1;
  localparam logic [1:0] SEG_GREEN_YELLOW = 2'd2;
  localparam logic [1:0] SEG_YELLOW_RED   = 2'd3;

  localparam logic [DATA_W-1:0] CH_MAX = 8'hFF;

endpackage

// File: rtl/gray_colormap.sv
// Combinational gray -> RGB mapper: gray replication by default,
// four-segment heat map when GRAY_TO_RGB_PSEUDOCOLOR_EN is defined.
module gray_colormap
  import gray_to_rgb_pkg::*;
(
  input  logic [DATA_W-1:0] gray_i,
  output rgb_t              rgb_o
);

`ifdef GRAY_TO_RGB_PSEUDOCOLOR_EN
  logic [1:0]        seg;
  logic [DATA_W-1:0] ramp;

  // The top two bits pick the segment; the low six bits form a 0..252 ramp.
  assign seg  = gray_i[7:6];
  assign ramp = {gray_i[5:0], 2'b00};

  always_comb begin
    rgb_o = '0;
    case (seg)
      SEG_BLUE_CYAN: begin
        rgb_o.r = '0;
        rgb_o.g = ramp;
        rgb_o.b = CH_MAX;
      end
      SEG_CYAN_GREEN: begin
        rgb_o.r = '0;
        rgb_o.g = CH_MAX;
        rgb_o.b = CH_MAX - ramp;
      end
      SEG_GREEN_YELLOW: begin
        rgb_o.r = ramp;
        rgb_o.g = CH_MAX;
        rgb_o.b = '0;
      end
      SEG_YELLOW_RED: begin
        rgb_o.r = CH_MAX;
        rgb_o.g = CH_MAX - ramp;
        rgb_o.b = '0;
      end
      default: rgb_o = '0;
    endcase
  end
`else
  always_comb begin
    rgb_o   = '0;
    rgb_o.r = gray_i;
    rgb_o.g = gray_i;
    rgb_o.b = gray_i;
  end
`endif

endmodule

// File: rtl/gray_to_rgb.sv
// One-cycle registered gray-to-RGB stage with a done strobe pipeline.
// Colour map chosen at build time by GRAY_TO_RGB_PSEUDOCOLOR_EN.
module gray_to_rgb
  import gray_to_rgb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] grayscale_i,
  input  logic              done_i,
  output logic [DATA_W-1:0] red_o,
  output logic [DATA_W-1:0] green_o,
  output logic [DATA_W-1:0] blue_o,
  output logic              done_o
);

  rgb_t mapped;
  rgb_t rgb_d, rgb_q;
  logic done_d, done_q;

  gray_colormap u_colormap (
    .gray_i (grayscale_i),
    .rgb_o  (mapped)
  );

  // Colour registers only load on a valid sample; otherwise they hold.
  always_comb begin
    rgb_d  = rgb_q;
    done_d = done_i;
    if (done_i) begin
      rgb_d = mapped;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rgb_q  <= '0;
      done_q <= 1'b0;
    end else begin
      rgb_q  <= rgb_d;
      done_q <= done_d;
    end
  end

  assign red_o   = rgb_q.r;
  assign green_o = rgb_q.g;
  assign blue_o  = rgb_q.b;
  assign done_o  = done_q;

endmodule

// File: tb/tb_gray_to_rgb.sv
// Self-checking bench for gray_to_rgb with a queue scoreboard; the
// reference map follows GRAY_TO_RGB_PSEUDOCOLOR_EN like the design.
module tb_gray_to_rgb;

  logic       clk;
  logic       rst;
  logic [7:0] grayscale_i;
  logic       done_i;
  logic [7:0] red_o, green_o, blue_o;
  logic       done_o;

  typedef struct {
    int r;
    int g;
    int b;
  } exp_rgb_t;

  exp_rgb_t exp_q[$];
  exp_rgb_t exp_rgb;
  int       exp_done;
  int       assert_cnt;
  int       fail_cnt;

  gray_to_rgb dut (
    .clk         (clk),
    .rst         (rst),
    .grayscale_i (grayscale_i),
    .done_i      (done_i),
    .red_o       (red_o),
    .green_o     (green_o),
    .blue_o      (blue_o),
    .done_o      (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference colour map written from the segment/ramp description.
  function automatic exp_rgb_t model_map(input int g);
    exp_rgb_t m;
`ifdef GRAY_TO_RGB_PSEUDOCOLOR_EN
    int s;
    int r;
    s = g / 64;
    r = (g % 64) * 4;
    case (s)
      0:       begin m.r = 0;       m.g = r;       m.b = 255;     end
      1:       begin m.r = 0;       m.g = 255;     m.b = 255 - r; end
      2:       begin m.r = r;       m.g = 255;     m.b = 0;       end
      default: begin m.r = 255;     m.g = 255 - r; m.b = 0;       end
    endcase
`else
    m.r = g;
    m.g = g;
    m.b = g;
`endif
    return m;
  endfunction

  task automatic compare(input string tag, input int observed, input int expected);
    assert_cnt++;
    assert (observed === expected) else begin
      fail_cnt++;
      $error("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag);
    if (exp_done == 1) begin
      if (exp_q.size() == 0) begin
        compare({tag, "_queue_empty"}, 0, 1);
      end else begin
        exp_rgb = exp_q.pop_front();
      end
    end
    compare({tag, "_done"},  int'(done_o),  exp_done);
    compare({tag, "_red"},   int'(red_o),   exp_rgb.r);
    compare({tag, "_green"}, int'(green_o), exp_rgb.g);
    compare({tag, "_blue"},  int'(blue_o),  exp_rgb.b);
  endtask

  // Drive one cycle of input, update the model at the edge, then check.
  task automatic applyStimulus(input string tag, input logic dv, input int g);
    done_i      = dv;
    grayscale_i = 8'(g);
    @(posedge clk);
    #1;
    if (rst) begin
      exp_done = int'(dv);
      if (dv) exp_q.push_back(model_map(g));
    end
    checkOutput(tag);
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_rgb.r = 0;
    exp_rgb.g = 0;
    exp_rgb.b = 0;
    exp_done  = 0;
  endtask

  initial begin
    int pc_vals[8];
    int tog_dv[5];
    assert_cnt  = 0;
    fail_cnt    = 0;
    pc_vals     = '{0, 63, 64, 127, 128, 191, 192, 255};
    tog_dv      = '{1, 0, 1, 1, 0};
    rst         = 1'b0;
    done_i      = 1'b0;
    grayscale_i = 8'd0;
    model_reset();

    $display("[TB] reset hold with done_i=1, gray=200");
    for (int i = 0; i < 3; i++) applyStimulus("rst_hold", 1'b1, 200);

    rst = 1'b1;
    $display("[TB] stream gray=1..9");
    for (int k = 1; k <= 9; k++) applyStimulus("stream", 1'b1, k);

    $display("[TB] hold behaviour");
    applyStimulus("hold_load", 1'b1, 9);
    applyStimulus("hold_0", 1'b0, 77);
    applyStimulus("hold_1", 1'b0, 77);

    $display("[TB] extremes and segment boundaries");
    for (int i = 0; i < 8; i++) applyStimulus("map", 1'b1, pc_vals[i]);
    applyStimulus("map_idle", 1'b0, 33);

    $display("[TB] done_i toggling");
    for (int i = 0; i < 5; i++) applyStimulus("toggle", tog_dv[i][0], 10 + i);
    applyStimulus("toggle_tail", 1'b0, 99);

    $display("[TB] asynchronous reset mid-stream");
    applyStimulus("pre_rst", 1'b1, 50);
    applyStimulus("pre_rst2", 1'b1, 200);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    checkOutput("async_rst");
    applyStimulus("in_rst", 1'b1, 120);
    rst = 1'b1;
    applyStimulus("post_rst", 1'b1, 60);
    applyStimulus("post_rst_idle", 1'b0, 61);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
